// File: rtl/touch_i2c_pkg.sv
// touch_i2c_pkg: shared constants, FSM states and helpers for the touch-panel I2C arbiter
package touch_i2c_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;
   localparam int TIMEOUT_DEF = 200000;
   localparam int MAX_REQ = 8;
   localparam int IDX_W = 3;
   typedef enum logic [2:0] {IDLE, GRANT, EXEC, WAIT, RELEASE} state_t;
   function automatic logic [IDX_W-1:0] oh2idx(input logic [MAX_REQ-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) if (oh[i]) idx = idx | IDX_W'(i);
      return idx;
   endfunction
endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr (cyclic)
module rr_pick
   import touch_i2c_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     win,
   output logic             valid
);
   int k;
   always_comb begin
      win = '0;
      k = 0;
      for (int i = 0; i < N; i++) begin
         k = (int'(ptr) + i) % N;
         if (win == '0 && req[k +: 1] == 1'b1) win[k +: 1] = 1'b1;
      end
   end
   assign valid = |req;
endmodule

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin sharing of one I2C master among NUM_REQ requesters,
// holding the grant for a whole transaction and aborting it after TIMEOUT cycles.
module i2c_bus_arbiter
   import touch_i2c_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         req_rh_wl,
   input  logic [ADDR_W*NUM_REQ-1:0]  req_addr,
   input  logic [DATA_W*NUM_REQ-1:0]  req_data_w,
   input  logic [NUM_REQ-1:0]         req_bit_ctrl,
   input  logic [WIDTH*NUM_REQ-1:0]   req_reg_num,
   output logic [NUM_REQ-1:0]         grant,
   output logic [NUM_REQ-1:0]         done,
   output logic [NUM_REQ-1:0]         once_done_o,
   output logic [NUM_REQ-1:0]         ack_o,
   output logic [NUM_REQ-1:0]         timeout_err,
   output logic [DATA_W-1:0]          data_r,
   output logic                       i2c_exec,
   output logic                       i2c_rh_wl,
   output logic [ADDR_W-1:0]          i2c_addr,
   output logic [DATA_W-1:0]          i2c_data_w,
   output logic                       bit_ctrl,
   output logic [WIDTH-1:0]           reg_num,
   input  logic                       i2c_done,
   input  logic                       once_done,
   input  logic                       ack,
   input  logic [DATA_W-1:0]          i2c_data_r
);
   localparam int CW = $clog2(TIMEOUT + 1);
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [IDX_W-1:0] ptr, owner;
   logic [NUM_REQ-1:0] win;
   logic win_valid, expire, in_wait;
   int oi;
   rr_pick #(.N(NUM_REQ)) u_pick (.req(req), .ptr(ptr), .win(win), .valid(win_valid));
   assign data_r = i2c_data_r;
   assign oi = int'(owner);
   assign in_wait = state == WAIT;
   assign expire = cnt == CW'(TIMEOUT - 1);
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = win_valid ? GRANT : IDLE;
         GRANT:   state_n = EXEC;
         EXEC:    state_n = WAIT;
         WAIT:    state_n = (i2c_done || expire) ? RELEASE : WAIT;
         RELEASE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state       <= IDLE;
         ptr         <= '0;
         owner       <= '0;
         cnt         <= '0;
         grant       <= '0;
         done        <= '0;
         once_done_o <= '0;
         ack_o       <= '0;
         timeout_err <= '0;
         i2c_exec    <= 1'b0;
         i2c_rh_wl   <= 1'b0;
         i2c_addr    <= '0;
         i2c_data_w  <= '0;
         bit_ctrl    <= 1'b0;
         reg_num     <= '0;
      end else begin
         state       <= state_n;
         i2c_exec    <= state == GRANT;
         cnt         <= in_wait ? cnt + CW'(1) : '0;
         done        <= (in_wait && i2c_done) ? grant : '0;
         // a completion seen on the expiry cycle takes precedence over the abort
         timeout_err <= (in_wait && !i2c_done && expire) ? grant : '0;
         once_done_o <= (in_wait && once_done) ? grant : '0;
         ack_o       <= (in_wait && ack) ? grant : '0;
         if (state == IDLE && win_valid) begin
            grant <= win;
            owner <= oh2idx(MAX_REQ'(win));
         end
         if (state == GRANT) begin
            i2c_rh_wl  <= req_rh_wl[oi +: 1] == 1'b1;
            i2c_addr   <= req_addr[ADDR_W*oi +: ADDR_W];
            i2c_data_w <= req_data_w[DATA_W*oi +: DATA_W];
            bit_ctrl   <= req_bit_ctrl[oi +: 1] == 1'b1;
            reg_num    <= req_reg_num[WIDTH*oi +: WIDTH];
         end
         if (state == RELEASE) begin
            grant <= '0;
            ptr   <= (oi == NUM_REQ - 1) ? '0 : owner + IDX_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: randomized transactions against a round-robin ownership model
module tb_i2c_bus_arbiter;
   localparam int N = 2;
   localparam int W = 8;
   localparam int TO = 50;
   localparam int AW = 16 * N;
   localparam int DW = 8 * N;
   localparam int RW = W * N;
   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   logic [N-1:0] req = '0, req_rh_wl = '0, req_bit_ctrl = '0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_data_w = '0;
   logic [RW-1:0] req_reg_num = '0;
   logic [N-1:0] grant, done, once_done_o, ack_o, timeout_err;
   logic [7:0] data_r, i2c_data_w;
   logic [7:0] i2c_data_r = '0;
   logic i2c_exec, i2c_rh_wl, bit_ctrl;
   logic [15:0] i2c_addr;
   logic [W-1:0] reg_num;
   logic i2c_done = 1'b0, once_done = 1'b0, ack = 1'b0;
   int vectors = 0, miscompares = 0, ptr = 0;

   always #5 sys_clk = ~sys_clk;

   i2c_bus_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req), .req_rh_wl(req_rh_wl),
      .req_addr(req_addr), .req_data_w(req_data_w), .req_bit_ctrl(req_bit_ctrl),
      .req_reg_num(req_reg_num), .grant(grant), .done(done), .once_done_o(once_done_o),
      .ack_o(ack_o), .timeout_err(timeout_err), .data_r(data_r), .i2c_exec(i2c_exec),
      .i2c_rh_wl(i2c_rh_wl), .i2c_addr(i2c_addr), .i2c_data_w(i2c_data_w),
      .bit_ctrl(bit_ctrl), .reg_num(reg_num), .i2c_done(i2c_done), .once_done(once_done),
      .ack(ack), .i2c_data_r(i2c_data_r)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r);
      for (int i = 0; i < N; i++) if (r[(ptr + i) % N]) return (ptr + i) % N;
      return 0;
   endfunction

   task automatic rand_fields();
      req_addr = AW'($urandom);
      req_data_w = DW'($urandom);
      req_rh_wl = N'($urandom);
      req_bit_ctrl = N'($urandom);
      req_reg_num = RW'($urandom);
   endtask

   // entered and left at the falling edge of a cycle in which the arbiter is idle
   task automatic txn(input logic [N-1:0] r, input int dd, input bit burst, input bit mutate,
                      input int rst_at);
      int own, sent, seen;
      logic [N-1:0] oh;
      logic [15:0] ea;
      logic [17:0] ecmd;
      bit po, pa, hit;
      own = pick(r);
      oh = '0;
      oh[own] = 1'b1;
      req = r;
      ea = req_addr[16*own +: 16];
      ecmd = {req_rh_wl[own], req_bit_ctrl[own], req_data_w[8*own +: 8], req_reg_num[W*own +: W]};
      @(negedge sys_clk);
      check("grant", 32'(grant), 32'(oh));
      check("exec_early", 32'(i2c_exec), 0);
      @(negedge sys_clk);
      check("exec", 32'(i2c_exec), 1);
      check("addr", 32'(i2c_addr), 32'(ea));
      check("cmd", 32'({i2c_rh_wl, bit_ctrl, i2c_data_w, reg_num}), 32'(ecmd));
      i2c_done = 1'($urandom);
      once_done = 1'($urandom);
      ack = 1'($urandom);
      po = 1'b0; pa = 1'b0; hit = 1'b0; sent = 0; seen = 0;
      for (int j = 0; j < TO; j++) begin
         @(negedge sys_clk);
         check("once_o", 32'(once_done_o), 32'(po ? oh : '0));
         check("ack_o", 32'(ack_o), 32'(pa ? oh : '0));
         check("done_wait", 32'(done), 0);
         check("to_wait", 32'(timeout_err), 0);
         check("grant_hold", 32'(grant), 32'(oh));
         check("addr_hold", 32'(i2c_addr), 32'(ea));
         if (once_done_o[own]) seen++;
         if (j == rst_at) begin
            i2c_done = 1'b0; once_done = 1'b0; ack = 1'b0;
            sys_rst = 1'b1;
            @(negedge sys_clk);
            sys_rst = 1'b0;
            check("rst_grant", 32'(grant), 0);
            check("rst_done", 32'({done, timeout_err, once_done_o, ack_o}), 0);
            check("rst_exec", 32'(i2c_exec), 0);
            check("rst_cmd", 32'({i2c_addr, i2c_rh_wl, bit_ctrl, i2c_data_w, reg_num}), 0);
            ptr = 0;
            return;
         end
         hit = j == dd;
         i2c_done = hit;
         once_done = burst ? (j >= 2 && j <= 8 && j % 2 == 0) : 1'($urandom);
         ack = burst ? 1'b1 : 1'($urandom);
         i2c_data_r = 8'($urandom);
         #1 check("data_r", 32'(data_r), 32'(i2c_data_r));
         po = once_done;
         pa = ack;
         if (once_done) sent++;
         if (mutate && j == 1) req_addr[16*own +: 16] = req_addr[16*own +: 16] + 16'd2;
         if (mutate && j == 2) req[own] = 1'b0;
         if (hit) break;
      end
      @(negedge sys_clk);
      check("done", 32'(done), 32'(hit ? oh : '0));
      check("timeout", 32'(timeout_err), 32'(hit ? '0 : oh));
      check("once_rel", 32'(once_done_o), 32'(po ? oh : '0));
      check("ack_rel", 32'(ack_o), 32'(pa ? oh : '0));
      check("addr_rel", 32'(i2c_addr), 32'(ea));
      if (once_done_o[own]) seen++;
      i2c_done = 1'($urandom);
      once_done = 1'($urandom);
      ack = 1'($urandom);
      @(negedge sys_clk);
      check("grant_idle", 32'(grant), 0);
      check("quiet_idle", 32'({done, timeout_err, once_done_o, ack_o}), 0);
      check("once_cnt", 32'(seen), 32'(sent));
      i2c_done = 1'b0; once_done = 1'b0; ack = 1'b0;
      ptr = (own + 1) % N;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge sys_clk);
      check("reset_grant", 32'(grant), 0);
      check("reset_outs", 32'({done, timeout_err, once_done_o, ack_o}), 0);
      check("reset_exec", 32'(i2c_exec), 0);
      check("reset_cmd", 32'({i2c_addr, i2c_rh_wl, bit_ctrl, i2c_data_w, reg_num}), 0);
      sys_rst = 1'b0;
      repeat (4) begin
         rand_fields();
         txn(2'b11, int'($urandom_range(3, 20)), 1'b0, 1'b0, -1);
      end
      rand_fields();
      req_addr[15:0] = 16'h8150;
      req_rh_wl[0] = 1'b1;
      req_reg_num[W-1:0] = W'(4);
      txn(2'b01, 30, 1'b0, 1'b0, -1);
      rand_fields();
      txn(2'b10, -1, 1'b0, 1'b0, -1);
      rand_fields();
      txn(2'b11, 5, 1'b0, 1'b0, -1);
      rand_fields();
      txn(2'b01, TO - 1, 1'b0, 1'b0, -1);
      rand_fields();
      req_rh_wl[1] = 1'b1;
      txn(2'b10, 12, 1'b1, 1'b0, -1);
      rand_fields();
      req_addr[15:0] = 16'h814E;
      txn(2'b01, 10, 1'b0, 1'b1, -1);
      rand_fields();
      txn(2'b11, -1, 1'b0, 1'b0, 5);
      rand_fields();
      txn(2'b11, 6, 1'b0, 1'b0, -1);
      repeat (30) begin
         rand_fields();
         txn(N'($urandom_range(1, 3)), ($urandom % 8 == 0) ? -1 : int'($urandom_range(0, 25)),
             1'b0, 1'($urandom), -1);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares the single touch-panel I2C master (exec/addr/data/done handshake) between NUM_REQ requesters, e.g. GT-series config, periodic coordinate poll, ID probe.
- Grants round-robin and holds the grant for one whole master transaction.
- Latches the winner's command fields and routes completion, ack and per-byte strobes back to the owner only.
- Guards against a hung bus with a per-transaction timeout.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WIDTH, 8, width of reg_num (registers per burst).
- TIMEOUT, 200000, sys_clk cycles allowed in WAIT before abort.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset. One clock; reset is synchronous and active-high.
- req  in  NUM_REQ  level request per requester, held until done/timeout_err.
- req_rh_wl  in  NUM_REQ  per requester: 1 = read, 0 = write.
- req_addr  in  16*NUM_REQ  register address, requester k at [16k+15:16k].
- req_data_w  in  8*NUM_REQ  write byte, requester k at [8k+7:8k].
- req_bit_ctrl  in  NUM_REQ  1 = 16-bit register address.
- req_reg_num  in  WIDTH*NUM_REQ  burst length.
- grant  out  NUM_REQ  one-hot owner, 0 when idle.
- done  out  NUM_REQ  one-cycle completion pulse to owner.
- once_done_o  out  NUM_REQ  per-byte strobe routed to owner.
- ack_o  out  NUM_REQ  master ack routed to owner.
- timeout_err  out  NUM_REQ  one-cycle abort pulse to owner.
- data_r  out  8  i2c_data_r pass-through, broadcast.
- i2c_exec  out  1  one-cycle start strobe to master.
- i2c_rh_wl, i2c_addr[15:0], i2c_data_w[7:0], bit_ctrl, reg_num[WIDTH-1:0]  out  latched command.
- i2c_done, once_done, ack  in  1  from master.
- i2c_data_r  in  8  read data from master.

Behaviour:
- Reset (sync, sys_rst=1): state IDLE, rr pointer 0, grant/done/once_done_o/ack_o/timeout_err/i2c_exec = 0, command regs 0. Applies mid-transaction with no completion pulse; the master is reset by its own reset.
- FSM:
  - IDLE: if req != 0, pick the first set bit at or after the pointer, cyclically → GRANT.
  - GRANT (1 cycle): grant one-hot registered; latch the owner's rh_wl/addr/data_w/bit_ctrl/reg_num → EXEC.
  - EXEC (1 cycle): i2c_exec = 1 → WAIT; clear the timeout counter.
  - WAIT: count every cycle.
    - On i2c_done: done[owner] = 1 for 1 cycle → RELEASE.
    - Else when counter == TIMEOUT-1: timeout_err[owner] = 1 for 1 cycle → RELEASE.
  - RELEASE (1 cycle): grant = 0; pointer = (owner+1) mod NUM_REQ → IDLE.
- Latency: req rising while IDLE at cycle n → grant at n+1, i2c_exec at n+2. Back-to-back transactions are separated by ≥1 idle cycle.
- Command fields stay stable from GRANT through RELEASE, even if the requester changes its inputs.
- Dropping req while owned is ignored; the transaction completes and done still pulses. A requester must deassert req the cycle after done, else it re-enters arbitration.
- once_done_o[owner] = once_done and ack_o[owner] = ack, registered, only in WAIT; 0 elsewhere. Non-owners always read 0.
- i2c_done and timeout in the same cycle: done wins, no timeout_err.
- i2c_done outside WAIT is ignored.
- Only one requester: it is served every transaction with no starvation. With all requesting, each is served once per NUM_REQ transactions.

Decomposition:
- Package touch_i2c_pkg: FSM state encoding (IDLE, GRANT, EXEC, WAIT, RELEASE), default TIMEOUT, field-width constants (ADDR_W=16, DATA_W=8).
- One combinational sub-module, rr_pick: takes req and pointer, returns a one-hot winner and a valid flag. Reusable by other arbiters.

Test Plan:
- Single request: req=01, addr0=0x8150, rh_wl=1, reg_num=4, i2c_done 30 cycles after exec → grant=01 at n+1, i2c_exec one cycle at n+2 with i2c_addr=0x8150, done[0] one pulse, grant=00 the cycle after.
- Contention: req=11 held continuously, pointer 0 → grant sequence 01,10,01,10 across 4 transactions, with done pulsing on the matching bit each time.
- Timeout: TIMEOUT=50, req=10, i2c_done never asserted → timeout_err[1] exactly 50 cycles after entering WAIT, done stays 0, next grant goes to requester 0 if it is requesting.
- Routing: owner 1 in a read burst with 4 once_done pulses, ack=1 → once_done_o=10 four times, once_done_o[0]=0 throughout, data_r tracks i2c_data_r.
- Stability: requester changes req_addr from 0x814E to 0x8150 during WAIT → i2c_addr stays 0x814E until RELEASE.
- Reset mid-WAIT: sys_rst high for 1 cycle → next cycle grant=0, no done/timeout_err, pointer 0; req=11 then grants requester 0 first.
